wrr_pkt_arbiter: RTL

- Weighted round-robin arbiter with packet locking, for NoC router output-port allocation.
- Arbitrates N input VCs/ports; each winner holds the grant until its tail flit transfers.
- Each requester may send up to weight[i] consecutive packets per turn before priority rotates.
- Grant is combinational from registered state; transfer is qualified by a downstream ready.

---
 rtl/rnoc_arb_pkg.sv | 15 +
 rtl/rr_prio_pick.sv | 44 ++++
 rtl/wrr_pkt_arbiter.sv | 191 +++++++++++++++++++
 3 files changed

// File: rtl/rnoc_arb_pkg.sv
// Shared types and helpers for the NoC arbitration blocks.
//   arb_state_e : packet-lock state of an output-port arbiter
//   idx_w(n)    : width of an index into n requesters (at least 1 bit)
package rnoc_arb_pkg;

    typedef enum logic {
        ARB_IDLE   = 1'b0,
        ARB_LOCKED = 1'b1
    } arb_state_e;

    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_prio_pick.sv
// Rotating-priority picker (purely combinational).
// Scans req_i starting at start_i and wrapping modulo N; the first set bit
// wins. start_i itself has the highest priority.
//   req_i   [N]     : request vector
//   start_i [IDX_W] : index with highest priority (must be < N)
//   grant_o [N]     : one-hot grant, all-zero when no request
//   idx_o   [IDX_W] : index of the granted bit, 0 when none
//   valid_o         : any request granted
module rr_prio_pick
    import rnoc_arb_pkg::*;
#(
    parameter int N = 5,
    localparam int IDX_W = idx_w(N)
) (
    input  logic [N-1:0]     req_i,
    input  logic [IDX_W-1:0] start_i,
    output logic [N-1:0]     grant_o,
    output logic [IDX_W-1:0] idx_o,
    output logic             valid_o
);

    int   k;
    logic found;

    always_comb begin
        grant_o = '0;
        idx_o   = '0;
        found   = 1'b0;
        k       = 0;
        for (int i = 0; i < N; i++) begin
            k = int'(start_i) + i;
            if (k >= N) begin
                k = k - N;
            end
            if (!found && req_i[k]) begin
                found      = 1'b1;
                grant_o[k] = 1'b1;
                idx_o      = IDX_W'(k);
            end
        end
        valid_o = found;
    end

endmodule

// File: rtl/wrr_pkt_arbiter.sv
// Weighted round-robin output-port arbiter with packet locking.
// A winner keeps the grant until its tail flit transfers. Each requester may
// complete up to weight[i] consecutive packets (0 counts as 1) while it holds
// priority before the pointer rotates past it.
//
// Handshake: a flit transfers on a cycle where grant_valid and out_ready are
// both high (xfer). The grant is combinational from registered state and is
// presented regardless of out_ready; state only advances on xfer (or on the
// optional lock timeout).
//
// Optional build macro ARB_LOCK_TIMEOUT_EN: adds lock_err and an idle counter
// that forcibly releases a lock whose owner has stopped requesting for
// LOCK_TIMEOUT cycles.
//
// Ports:
//   clk, rst     : clock, asynchronous active-high reset
//   req [N]      : per-requester flit valid
//   tail [N]     : per-requester "current flit is a tail"
//   weight [N*W] : static weights, field i = weight[i*W_BITS +: W_BITS]
//   out_ready    : downstream accepts a flit
//   grant [N]    : one-hot grant
//   grant_idx    : granted index (0 when none)
//   grant_valid  : |grant
//   locked       : held by an in-progress packet (the FSM state)
//   lock_err     : one-cycle pulse on forced unlock (ARB_LOCK_TIMEOUT_EN only)
module wrr_pkt_arbiter
    import rnoc_arb_pkg::*;
#(
    parameter int N            = 5,
    parameter int W_BITS       = 3,
    parameter int LOCK_TIMEOUT = 16,
    localparam int IDX_W = idx_w(N)
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [N-1:0]        req,
    input  logic [N-1:0]        tail,
    input  logic [N*W_BITS-1:0] weight,
    input  logic                out_ready,
    output logic [N-1:0]        grant,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid,
    output logic                locked
`ifdef ARB_LOCK_TIMEOUT_EN
    ,
    output logic                lock_err
`endif
);

    arb_state_e        st_q, st_d;
    logic [IDX_W-1:0]  owner_q, owner_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;
    logic [W_BITS-1:0] cnt_q, cnt_d;

    logic [N-1:0]      pick_grant;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;

    logic              xfer;
    logic              win_tail;
    logic              owner_req;
    logic [W_BITS:0]   n_done;
    logic [W_BITS:0]   eff_w;
    logic [W_BITS-1:0] w_field;

    function automatic logic [IDX_W-1:0] inc_mod(input logic [IDX_W-1:0] v);
        if (int'(v) >= N - 1) begin
            return '0;
        end
        return v + IDX_W'(1);
    endfunction

    rr_prio_pick #(
        .N(N)
    ) u_pick (
        .req_i   (req),
        .start_i (ptr_q),
        .grant_o (pick_grant),
        .idx_o   (pick_idx),
        .valid_o (pick_valid)
    );

    assign owner_req = req[owner_q];

    // Grant path: free search while idle, owner-only while locked.
    always_comb begin
        grant     = '0;
        grant_idx = '0;
        if (st_q == ARB_LOCKED) begin
            if (owner_req) begin
                grant[owner_q] = 1'b1;
                grant_idx      = owner_q;
            end
        end else if (pick_valid) begin
            grant     = pick_grant;
            grant_idx = pick_idx;
        end
    end

    assign grant_valid = |grant;
    assign locked      = (st_q == ARB_LOCKED);
    assign xfer        = grant_valid & out_ready;
    assign win_tail    = tail[grant_idx];

    // Packet-completion bookkeeping. The count only continues when the same
    // requester that holds priority completes again; anyone else restarts
    // at 1. One extra bit keeps cnt+1 from wrapping.
    always_comb begin
        w_field = weight[int'(grant_idx)*W_BITS +: W_BITS];
        eff_w   = (w_field == '0) ? (W_BITS+1)'(1) : {1'b0, w_field};
        if (grant_idx == ptr_q) begin
            n_done = {1'b0, cnt_q} + (W_BITS+1)'(1);
        end else begin
            n_done = (W_BITS+1)'(1);
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    localparam int TMO_W = $clog2(LOCK_TIMEOUT + 1);
    logic [TMO_W-1:0] tmo_q, tmo_d;
    logic             lock_err_q, lock_err_d;
    assign lock_err = lock_err_q;
`endif

    always_comb begin
        st_d    = st_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        cnt_d   = cnt_q;
`ifdef ARB_LOCK_TIMEOUT_EN
        tmo_d      = '0;
        lock_err_d = 1'b0;
`endif
        if (xfer) begin
            if (win_tail) begin
                st_d = ARB_IDLE;
                if (n_done >= eff_w) begin
                    ptr_d = inc_mod(grant_idx);
                    cnt_d = '0;
                end else begin
                    ptr_d = grant_idx;
                    cnt_d = n_done[W_BITS-1:0];
                end
            end else if (st_q == ARB_IDLE) begin
                st_d    = ARB_LOCKED;
                owner_d = grant_idx;
            end
        end
`ifdef ARB_LOCK_TIMEOUT_EN
        // An idle owner cannot transfer, so this never races with xfer.
        if (st_q == ARB_LOCKED && !owner_req) begin
            if (int'(tmo_q) + 1 >= LOCK_TIMEOUT) begin
                st_d       = ARB_IDLE;
                ptr_d      = inc_mod(owner_q);
                cnt_d      = '0;
                lock_err_d = 1'b1;
                tmo_d      = '0;
            end else begin
                tmo_d = tmo_q + TMO_W'(1);
            end
        end
`endif
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            st_q    <= ARB_IDLE;
            owner_q <= '0;
            ptr_q   <= '0;
            cnt_q   <= '0;
        end else begin
            st_q    <= st_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            cnt_q   <= cnt_d;
        end
    end

`ifdef ARB_LOCK_TIMEOUT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tmo_q      <= '0;
            lock_err_q <= 1'b0;
        end else begin
            tmo_q      <= tmo_d;
            lock_err_q <= lock_err_d;
        end
    end
`endif

endmodule
